// File: rtl/wr_fault_responder_pkg.sv
// Shared types for the write-path fault responder: AXI channel payloads,
// FSM state encoding, outstanding-table slot and AXI response codes.
package wr_fault_responder_pkg;

    localparam int unsigned IdWidth   = 4;
    localparam int unsigned AddrWidth = 32;
    localparam int unsigned DataWidth = 32;
    localparam int unsigned StrbWidth = DataWidth / 8;

    typedef logic [IdWidth-1:0] axi_id_t;

    typedef struct packed {
        axi_id_t                id;
        logic [AddrWidth-1:0]   addr;
        logic [7:0]             len;
        logic [2:0]             size;
        logic [1:0]             burst;
    } axi_aw_chan_t;

    typedef struct packed {
        logic [DataWidth-1:0]   data;
        logic [StrbWidth-1:0]   strb;
        logic                   last;
    } axi_w_chan_t;

    typedef struct packed {
        axi_id_t                id;
        logic [1:0]             resp;
    } axi_b_chan_t;

    typedef struct packed {
        axi_aw_chan_t           aw;
        logic                   aw_valid;
        axi_w_chan_t            w;
        logic                   w_valid;
        logic                   b_ready;
    } axi_req_t;

    typedef struct packed {
        logic                   aw_ready;
        logic                   w_ready;
        axi_b_chan_t            b;
        logic                   b_valid;
    } axi_rsp_t;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        PASS    = 2'd0,
        DRAIN_W = 2'd1,
        ERR_B   = 2'd2,
        HOLD    = 2'd3
    } state_e;

    typedef struct packed {
        axi_id_t                id;
        logic                   valid;
    } ost_slot_t;

endpackage

// File: rtl/wr_ost_table.sv
// Outstanding-write table: MaxWrTxns {id, valid} slots.
// Ports:
//   clk_i, rst_ni     clock, async active-low reset
//   alloc_i/_id_i     claim the lowest free slot for a new write
//   release_i/_id_i   free the lowest valid slot whose id matches
//   pop_i             free the lowest valid slot (error-B drain)
//   clear_i           invalidate every slot
//   full_c, empty_c   occupancy flags (decoded from slot registers)
//   head_id_c         id held in the lowest valid slot
module wr_ost_table
    import wr_fault_responder_pkg::*;
#(
    parameter int unsigned MaxWrTxns = 32
) (
    input  logic    clk_i,
    input  logic    rst_ni,
    input  logic    alloc_i,
    input  axi_id_t alloc_id_i,
    input  logic    release_i,
    input  axi_id_t release_id_i,
    input  logic    pop_i,
    input  logic    clear_i,
    output logic    full_c,
    output logic    empty_c,
    output axi_id_t head_id_c
);

    localparam int unsigned IdxWidth = (MaxWrTxns > 1) ? $clog2(MaxWrTxns) : 1;

    ost_slot_t [MaxWrTxns-1:0] slots_q, slots_d;
    logic      [MaxWrTxns-1:0] valid_vec, match_vec;
    logic      [IdxWidth-1:0]  free_idx, match_idx, head_idx;
    logic                      free_found, match_found, head_found;

    // Index of the lowest set bit; 0 when none is set.
    function automatic logic [IdxWidth-1:0] lowest_set(input logic [MaxWrTxns-1:0] vec);
        logic [IdxWidth-1:0] idx;
        idx = '0;
        for (int i = int'(MaxWrTxns) - 1; i >= 0; i--) begin
            if (vec[i]) idx = IdxWidth'(i);
        end
        return idx;
    endfunction

    // Per-slot occupancy and release-id match vectors.
    always_comb begin
        valid_vec = '0;
        match_vec = '0;
        for (int unsigned i = 0; i < MaxWrTxns; i++) begin
            valid_vec[i] = slots_q[i].valid;
            match_vec[i] = slots_q[i].valid && (slots_q[i].id == release_id_i);
        end
    end

    assign free_idx    = lowest_set(~valid_vec);
    assign free_found  = ~&valid_vec;
    assign match_idx   = lowest_set(match_vec);
    assign match_found = |match_vec;
    assign head_idx    = lowest_set(valid_vec);
    assign head_found  = |valid_vec;

    assign full_c    = &valid_vec;
    assign empty_c   = ~|valid_vec;
    assign head_id_c = slots_q[head_idx].id;

    // Slot update; alloc targets a free slot and release/pop a valid one,
    // so they never collide on the same entry.
    always_comb begin
        slots_d = slots_q;
        if (clear_i) begin
            slots_d = '0;
        end else begin
            if (alloc_i && free_found) begin
                slots_d[free_idx] = '{id: alloc_id_i, valid: 1'b1};
            end
            if (release_i && match_found) begin
                slots_d[match_idx].valid = 1'b0;
            end
            if (pop_i && head_found) begin
                slots_d[head_idx].valid = 1'b0;
            end
        end
    end

    // Slot storage.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            slots_q <= '0;
        end else begin
            slots_q <= slots_d;
        end
    end

endmodule

// File: rtl/wr_fault_responder.sv
// AXI write-path isolation stage behind write_guard. Forwards AW/W/B
// untouched in PASS while tracking outstanding writes; on a guard reset
// request it cuts off the slave, sinks the master's pending W beats,
// answers every outstanding write with an error B and then holds the
// slave isolated until reset_clear_i.
// Build option: WR_FAULT_RESP_DECERR_EN selects DECERR instead of SLVERR
// for the error responses.
// Ports:
//   clk_i, rst_ni     clock, async active-low reset
//   reset_req_i       fault request level from write_guard
//   reset_clear_i     one-cycle pulse, slave reset complete
//   mst_req_i/rsp_o   master-facing AXI write port
//   slv_req_o/rsp_i   slave-facing AXI write port
//   isolated_o        high in every state except PASS
//   drain_done_o      high in HOLD only
module wr_fault_responder
    import wr_fault_responder_pkg::*;
#(
    parameter int unsigned MaxWrTxns = 32,
    parameter type         req_t     = axi_req_t,
    parameter type         rsp_t     = axi_rsp_t,
    parameter type         id_t      = axi_id_t
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic reset_req_i,
    input  logic reset_clear_i,
    input  req_t mst_req_i,
    output rsp_t mst_rsp_o,
    output req_t slv_req_o,
    input  rsp_t slv_rsp_i,
    output logic isolated_o,
    output logic drain_done_o
);

    localparam int unsigned PendWidth = $clog2(MaxWrTxns + 1);

`ifdef WR_FAULT_RESP_DECERR_EN
    localparam logic [1:0] ErrResp = AXI_RESP_DECERR;
`else
    localparam logic [1:0] ErrResp = AXI_RESP_SLVERR;
`endif

    state_e                 state_q, state_d;
    logic [PendWidth-1:0]   w_pend_q, w_pend_d;
    logic                   isolated_q, drain_done_q;

    logic                   tbl_full, tbl_empty, tbl_clear;
    axi_id_t                tbl_head_id;
    id_t                    head_id;

    logic in_pass, aw_hs, w_last_hs, b_hs, err_b_valid, err_b_hs;

    assign in_pass = (state_q == PASS);

    // Slave-side AW handshake; a full table stalls AW on both sides.
    assign aw_hs = in_pass && mst_req_i.aw_valid && slv_rsp_i.aw_ready && !tbl_full;

    // Final W beat: forwarded in PASS, sunk unconditionally in DRAIN_W.
    assign w_last_hs = mst_req_i.w_valid && mst_req_i.w.last &&
                       ((in_pass && slv_rsp_i.w_ready) || (state_q == DRAIN_W));

    // Slave B forwarded to the master; non-PASS Bs are dropped.
    assign b_hs = in_pass && slv_rsp_i.b_valid && mst_req_i.b_ready;

    // Error B is a decode of state and table registers, so it stays
    // stable with the head id until the master accepts it.
    assign err_b_valid = (state_q == ERR_B) && !tbl_empty;
    assign err_b_hs    = err_b_valid && mst_req_i.b_ready;

    assign head_id = id_t'(tbl_head_id);

    wr_ost_table #(
        .MaxWrTxns   (MaxWrTxns)
    ) u_table (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .alloc_i     (aw_hs),
        .alloc_id_i  (axi_id_t'(mst_req_i.aw.id)),
        .release_i   (b_hs),
        .release_id_i(axi_id_t'(slv_rsp_i.b.id)),
        .pop_i       (err_b_hs),
        .clear_i     (tbl_clear),
        .full_c      (tbl_full),
        .empty_c     (tbl_empty),
        .head_id_c   (tbl_head_id)
    );

    // Next state, W-pending count and table clear.
    always_comb begin
        state_d   = state_q;
        w_pend_d  = w_pend_q;
        tbl_clear = 1'b0;

        if (aw_hs && !w_last_hs) begin
            w_pend_d = w_pend_q + PendWidth'(1);
        end else if (!aw_hs && w_last_hs && (w_pend_q != '0)) begin
            w_pend_d = w_pend_q - PendWidth'(1);
        end

        unique case (state_q)
            PASS: begin
                if (reset_req_i) state_d = DRAIN_W;
            end
            DRAIN_W: begin
                if (w_pend_q == '0) state_d = ERR_B;
            end
            ERR_B: begin
                if (tbl_empty) state_d = HOLD;
            end
            HOLD: begin
                if (reset_clear_i) begin
                    state_d   = PASS;
                    w_pend_d  = '0;
                    tbl_clear = 1'b1;
                end
            end
            default: state_d = PASS;
        endcase
    end

    // State, counter and status registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= PASS;
            w_pend_q     <= '0;
            isolated_q   <= 1'b0;
            drain_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            w_pend_q     <= w_pend_d;
            isolated_q   <= (state_d != PASS);
            drain_done_q <= (state_d == HOLD);
        end
    end

    assign isolated_o   = isolated_q;
    assign drain_done_o = drain_done_q;

    // Channel muxing: transparent in PASS, isolated otherwise.
    always_comb begin
        slv_req_o = mst_req_i;
        mst_rsp_o = slv_rsp_i;
        if (in_pass) begin
            slv_req_o.aw_valid = mst_req_i.aw_valid && !tbl_full;
            mst_rsp_o.aw_ready = slv_rsp_i.aw_ready && !tbl_full;
        end else begin
            slv_req_o.aw_valid = 1'b0;
            slv_req_o.w_valid  = 1'b0;
            slv_req_o.b_ready  = 1'b1;
            mst_rsp_o          = '0;
            mst_rsp_o.w_ready  = (state_q == DRAIN_W);
            mst_rsp_o.b_valid  = err_b_valid;
            mst_rsp_o.b.id     = head_id;
            mst_rsp_o.b.resp   = ErrResp;
        end
    end

endmodule

// File: tb/tb_wr_fault_responder.sv
// Directed bench for wr_fault_responder: passthrough, table-full stall,
// fault drain with error Bs, backpressure, recovery and async reset.
module tb_wr_fault_responder;
    import wr_fault_responder_pkg::*;

    localparam int unsigned MaxTxns = 32;
`ifdef WR_FAULT_RESP_DECERR_EN
    localparam logic [1:0] ExpErr = 2'b11;
`else
    localparam logic [1:0] ExpErr = 2'b10;
`endif

    typedef struct packed {
        axi_id_t    id;
        logic [1:0] resp;
    } exp_b_t;

    logic     clk = 1'b0;
    logic     rst_n, reset_req, reset_clear;
    axi_req_t mst_req, slv_req;
    axi_rsp_t mst_rsp, slv_rsp;
    logic     isolated, drain_done;

    int       n_vec  = 0;
    int       n_fail = 0;
    exp_b_t   exp_q[$];

    always #5 clk = ~clk;

    wr_fault_responder #(
        .MaxWrTxns    (MaxTxns),
        .req_t        (axi_req_t),
        .rsp_t        (axi_rsp_t),
        .id_t         (axi_id_t)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .reset_req_i  (reset_req),
        .reset_clear_i(reset_clear),
        .mst_req_i    (mst_req),
        .mst_rsp_o    (mst_rsp),
        .slv_req_o    (slv_req),
        .slv_rsp_i    (slv_rsp),
        .isolated_o   (isolated),
        .drain_done_o (drain_done)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Master AW in PASS; slave always ready. Bounded wait for acceptance.
    task automatic send_aw(input axi_id_t id);
        logic        done;
        logic [31:0] addr;
        done = 1'b0;
        addr = 32'h0000_1000 | (32'(id) << 4);
        mst_req.aw       = '0;
        mst_req.aw.id    = id;
        mst_req.aw.addr  = addr;
        mst_req.aw.len   = 8'd1;
        mst_req.aw_valid = 1'b1;
        slv_rsp.aw_ready = 1'b1;
        for (int t = 0; t < 8; t++) begin
            if (!done) begin
                #1;
                if (mst_rsp.aw_ready) begin
                    chk("aw_fwd_id", 64'(slv_req.aw.id), 64'(id));
                    chk("aw_fwd_addr", 64'(slv_req.aw.addr), 64'(addr));
                    done = 1'b1;
                end
                step();
            end
        end
        chk("aw_accepted", 64'(done), 64'(1'b1));
        mst_req.aw_valid = 1'b0;
    endtask

    // Master W burst in PASS, slave always ready.
    task automatic send_w(input int beats);
        logic [31:0] d;
        for (int b = 0; b < beats; b++) begin
            d = $urandom;
            mst_req.w.data  = d;
            mst_req.w.strb  = 4'hf;
            mst_req.w.last  = (b == beats - 1);
            mst_req.w_valid = 1'b1;
            slv_rsp.w_ready = 1'b1;
            #1;
            chk("w_fwd_ready", 64'(mst_rsp.w_ready), 64'(1'b1));
            chk("w_fwd_data", 64'(slv_req.w.data), 64'(d));
            step();
        end
        mst_req.w_valid = 1'b0;
    endtask

    // Slave returns an OKAY B; scoreboard expects it forwarded unchanged.
    task automatic slave_b(input axi_id_t id);
        exp_b_t e;
        exp_q.push_back('{id: id, resp: AXI_RESP_OKAY});
        slv_rsp.b_valid = 1'b1;
        slv_rsp.b.id    = id;
        slv_rsp.b.resp  = AXI_RESP_OKAY;
        mst_req.b_ready = 1'b1;
        #1;
        chk("b_fwd_valid", 64'(mst_rsp.b_valid), 64'(1'b1));
        e = exp_q.pop_front();
        chk("b_fwd_id", 64'(mst_rsp.b.id), 64'(e.id));
        chk("b_fwd_resp", 64'(mst_rsp.b.resp), 64'(e.resp));
        step();
        slv_rsp.b_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        exp_b_t e;
        logic   seen;
        int     nb;

        rst_n       = 1'b0;
        reset_req   = 1'b0;
        reset_clear = 1'b0;
        mst_req     = '0;
        slv_rsp     = '0;
        #1;
        chk("rst_mst_b_valid", 64'(mst_rsp.b_valid), 64'(1'b0));
        chk("rst_slv_aw_valid", 64'(slv_req.aw_valid), 64'(1'b0));
        chk("rst_slv_w_valid", 64'(slv_req.w_valid), 64'(1'b0));
        chk("rst_isolated", 64'(isolated), 64'(1'b0));
        chk("rst_drain_done", 64'(drain_done), 64'(1'b0));
        #20;
        rst_n = 1'b1;
        step();

        // Passthrough with out-of-order Bs.
        for (int i = 0; i < 4; i++) begin
            send_aw(axi_id_t'(i));
            send_w(2);
        end
        slave_b(axi_id_t'(2));
        slave_b(axi_id_t'(0));
        slave_b(axi_id_t'(3));
        slave_b(axi_id_t'(1));
        chk("pass_isolated", 64'(isolated), 64'(1'b0));

        // Table full: 32 accepted, #33 stalls until a B frees a slot.
        for (int i = 0; i < 32; i++) send_aw(axi_id_t'(i));
        mst_req.aw          = '0;
        mst_req.aw.id       = axi_id_t'(9);
        mst_req.aw_valid    = 1'b1;
        slv_rsp.aw_ready    = 1'b1;
        #1;
        chk("full_aw_ready", 64'(mst_rsp.aw_ready), 64'(1'b0));
        chk("full_slv_aw_valid", 64'(slv_req.aw_valid), 64'(1'b0));
        step();
        slave_b(axi_id_t'(3));
        #1;
        chk("full_freed_aw_ready", 64'(mst_rsp.aw_ready), 64'(1'b1));
        chk("full_freed_aw_id", 64'(slv_req.aw.id), 64'(9));
        step();
        mst_req.aw_valid = 1'b0;
        for (int i = 0; i < 33; i++) send_w(1);
        for (int i = 0; i < 32; i++) begin
            if (i != 3) slave_b(axi_id_t'(i));
        end
        slave_b(axi_id_t'(9));

        // Fault with W pending for IDs 6 and 7.
        send_aw(axi_id_t'(5));
        send_aw(axi_id_t'(6));
        send_aw(axi_id_t'(7));
        send_w(2);
        exp_q.push_back('{id: axi_id_t'(5), resp: ExpErr});
        exp_q.push_back('{id: axi_id_t'(6), resp: ExpErr});
        exp_q.push_back('{id: axi_id_t'(7), resp: ExpErr});
        reset_req = 1'b1;
        step();
        reset_req        = 1'b0;
        mst_req.aw       = '0;
        mst_req.aw.id    = axi_id_t'(8);
        mst_req.aw_valid = 1'b1;
        #1;
        chk("iso_isolated", 64'(isolated), 64'(1'b1));
        chk("iso_slv_aw_valid", 64'(slv_req.aw_valid), 64'(1'b0));
        chk("iso_mst_aw_ready", 64'(mst_rsp.aw_ready), 64'(1'b0));
        chk("iso_slv_b_ready", 64'(slv_req.b_ready), 64'(1'b1));
        chk("iso_drain_done", 64'(drain_done), 64'(1'b0));
        mst_req.aw_valid = 1'b0;
        reset_clear = 1'b1;
        step();
        reset_clear = 1'b0;
        #1;
        chk("clear_in_drain_ignored", 64'(isolated), 64'(1'b1));
        mst_req.b_ready = 1'b0;
        for (int b = 0; b < 4; b++) begin
            mst_req.w.data  = 32'(b);
            mst_req.w.last  = (b % 2 == 1);
            mst_req.w_valid = 1'b1;
            #1;
            chk("drain_w_ready", 64'(mst_rsp.w_ready), 64'(1'b1));
            chk("drain_slv_w_valid", 64'(slv_req.w_valid), 64'(1'b0));
            chk("drain_no_b_yet", 64'(mst_rsp.b_valid), 64'(1'b0));
            step();
        end
        mst_req.w_valid = 1'b0;
        #1;
        chk("errb_not_early", 64'(mst_rsp.b_valid), 64'(1'b0));
        step();

        // Backpressure: head error B held stable, late slave B dropped.
        for (int c = 0; c < 5; c++) begin
            if (c == 2) begin
                slv_rsp.b_valid = 1'b1;
                slv_rsp.b.id    = axi_id_t'(6);
                slv_rsp.b.resp  = AXI_RESP_OKAY;
            end
            #1;
            chk("bp_b_valid", 64'(mst_rsp.b_valid), 64'(1'b1));
            chk("bp_b_id", 64'(mst_rsp.b.id), 64'(5));
            chk("bp_b_resp", 64'(mst_rsp.b.resp), 64'(ExpErr));
            if (c == 2) chk("late_b_sunk", 64'(slv_req.b_ready), 64'(1'b1));
            step();
            slv_rsp.b_valid = 1'b0;
        end
        mst_req.b_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("errb_valid", 64'(mst_rsp.b_valid), 64'(1'b1));
            e = exp_q.pop_front();
            chk("errb_id", 64'(mst_rsp.b.id), 64'(e.id));
            chk("errb_resp", 64'(mst_rsp.b.resp), 64'(e.resp));
            step();
        end
        #1;
        chk("errb_done_valid", 64'(mst_rsp.b_valid), 64'(1'b0));
        chk("errb_done_not_hold", 64'(drain_done), 64'(1'b0));
        step();
        mst_req.w.last  = 1'b1;
        mst_req.w_valid = 1'b1;
        #1;
        chk("hold_drain_done", 64'(drain_done), 64'(1'b1));
        chk("hold_isolated", 64'(isolated), 64'(1'b1));
        chk("hold_w_ready", 64'(mst_rsp.w_ready), 64'(1'b0));
        chk("hold_slv_w_valid", 64'(slv_req.w_valid), 64'(1'b0));
        chk("sb_empty", 64'(exp_q.size()), 64'(0));
        mst_req.w_valid = 1'b0;

        // Recovery from HOLD.
        reset_clear = 1'b1;
        step();
        reset_clear = 1'b0;
        #1;
        chk("recover_isolated", 64'(isolated), 64'(1'b0));
        chk("recover_drain_done", 64'(drain_done), 64'(1'b0));
        send_aw(axi_id_t'(4));
        send_w(2);
        slave_b(axi_id_t'(4));

        // Async reset in the middle of ERR_B.
        send_aw(axi_id_t'(1));
        send_aw(axi_id_t'(2));
        send_w(1);
        send_w(1);
        reset_req = 1'b1;
        step();
        reset_req       = 1'b0;
        mst_req.b_ready = 1'b0;
        seen = 1'b0;
        for (int t = 0; t < 10; t++) begin
            if (!seen) begin
                if (mst_rsp.b_valid) seen = 1'b1;
                else step();
            end
        end
        chk("arst_reached_errb", 64'(seen), 64'(1'b1));
        slv_rsp = '0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_b_valid", 64'(mst_rsp.b_valid), 64'(1'b0));
        chk("arst_isolated", 64'(isolated), 64'(1'b0));
        chk("arst_drain_done", 64'(drain_done), 64'(1'b0));
        chk("arst_slv_aw_valid", 64'(slv_req.aw_valid), 64'(1'b0));
        chk("arst_slv_w_valid", 64'(slv_req.w_valid), 64'(1'b0));
        step();
        rst_n = 1'b1;
        step();

        // Table emptied by reset: a fault yields no error B at all.
        reset_req = 1'b1;
        step();
        reset_req = 1'b0;
        nb   = 0;
        seen = 1'b0;
        for (int t = 0; t < 10; t++) begin
            if (!seen) begin
                if (mst_rsp.b_valid) nb++;
                if (drain_done) seen = 1'b1;
                else step();
            end
        end
        chk("post_rst_no_err_b", 64'(nb), 64'(0));
        chk("post_rst_hold", 64'(seen), 64'(1'b1));
        reset_clear = 1'b1;
        step();
        reset_clear = 1'b0;
        #1;
        chk("post_rst_recover", 64'(isolated), 64'(1'b0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/wr_fault_responder.md
# wr_fault_responder

AXI write-path isolation stage placed directly downstream of `write_guard`, between the guarded master port and the monitored slave. In normal operation it forwards AW/W/B unchanged while tracking outstanding writes. When `write_guard` raises its reset request, the block cuts the slave off and drains the master cleanly: it sinks pending W beats and returns one error B response per outstanding write. It then holds the slave isolated until the reset is cleared.

## Interface
Parameters:
- `MaxWrTxns`, 32: outstanding-write table depth; must equal the guard's value.
- `req_t`, logic: AXI request struct.
- `rsp_t`, logic: AXI response struct.
- `id_t`, logic: AXI ID type.

Ports:
- `clk_i`  in  1: single clock.
- `rst_ni`  in  1: asynchronous, active-low reset.
- `reset_req_i`  in  1: fault request from `write_guard.reset_req_o`; level.
- `reset_clear_i`  in  1: one-cycle pulse, slave reset complete.
- `mst_req_i`  in  req_t: from master.
- `mst_rsp_o`  out  rsp_t: to master.
- `slv_req_o`  out  req_t: to slave; also drives the guard's `mst_req_i`.
- `slv_rsp_i`  in  rsp_t: from slave.
- `isolated_o`  out  1: high in every state except PASS.
- `drain_done_o`  out  1: high in HOLD only.

## Operation
- States: PASS, DRAIN_W, ERR_B, HOLD. Reset state is PASS.
- Outstanding table has `MaxWrTxns` slots, each `{id, valid}`.
  - Allocation: on a slave-side AW handshake, the lowest free slot is allocated.
  - Release: on a slave-side B handshake, the lowest valid slot with a matching ID is freed. A B with no matching ID is forwarded and the table is left unchanged.
- `w_pend` counter, width clog2(MaxWrTxns+1):
  - +1 on an AW handshake.
  - −1 on a W handshake with `w.last`.
  - Both in the same cycle: no change.
- PASS:
  - All AW/W/B fields are combinational pass-through.
  - When the table is full, AW is stalled: `aw_ready` to the master and `aw_valid` to the slave are both 0.
- PASS→DRAIN_W when `reset_req_i` is sampled high. A handshake completing in that same cycle is still recorded.
- Behaviour in every non-PASS state:
  - Slave side: `aw_valid`=0, `w_valid`=0, `b_ready`=1. Late slave Bs are dropped and do not touch the table.
  - Master side: `aw_ready`=0.
- DRAIN_W:
  - Master `w_ready`=1; W beats are discarded, and each `last` decrements `w_pend`.
  - Moves to ERR_B when `w_pend`==0.
- ERR_B:
  - Presents the lowest valid slot: `b_valid`=1, `b.id`=slot id, `b.resp`=error code.
  - On master `b_ready`, that slot is freed.
  - Moves to HOLD when the table is empty.
- HOLD:
  - Master W `w_ready`=0.
  - Moves to PASS on `reset_clear_i`, with the table and `w_pend` cleared.
- `reset_clear_i` in any state other than HOLD is ignored.
- `reset_req_i` while already isolated has no effect.

## Timing
- Values after reset: all valids to master and slave are 0, `isolated_o`=0, `drain_done_o`=0, the table is empty and `w_pend`=0.
- PASS path adds zero latency and has no registers in the data path.
- Isolation takes effect one cycle after `reset_req_i` is sampled.
- Error B: `b_valid` is registered and rises in the first ERR_B cycle.
  - Throughput is one error B per cycle while `b_ready`=1.
  - `b_valid` and `b.id` stay stable until the handshake.
- ERR_B is entered one cycle after `w_pend` reaches 0. If the table is already empty, the block passes through ERR_B for one cycle and then goes to HOLD.
- HOLD→PASS takes effect in the cycle after `reset_clear_i`.

## Configuration
- `WR_FAULT_RESP_DECERR_EN`:
  - Defined: error Bs carry DECERR (2'b11).
  - Undefined (default): error Bs carry SLVERR (2'b10).
- No other behaviour differs.

## Structure
- A shared package holds:
  - the state enum;
  - the slot typedef;
  - the resp-code localparams AXI_RESP_SLVERR and AXI_RESP_DECERR.
- Sub-module `wr_ost_table`:
  - holds the slot array and the allocate/release logic (lzc free-index and match-index);
  - outputs full, empty and the lowest valid slot.

## Test plan
- Passthrough: 4 AWs with IDs 0,1,2,3, each with a 2-beat W; slave Bs arrive out of order 2,0,3,1 → all forwarded unchanged, table ends empty, `isolated_o`=0.
- Full: issue 32 AWs with no B returned → AW #33 is stalled (`aw_ready`=0); after one B it is accepted the next cycle.
- Fault with W pending:
  - 3 AWs (IDs 5,6,7) accepted with only ID 5's W complete, then `reset_req_i`=1.
  - Expected: the master's remaining W beats are sunk, then 3 Bs return with IDs 5,6,7 and resp 2'b10 (2'b11 with the macro defined), then `drain_done_o`=1.
- Backpressure: master `b_ready`=0 for 5 cycles during ERR_B → `b_valid` and `b.id` held stable; a late slave B is dropped.
- Recovery: `reset_clear_i` pulse in DRAIN_W is ignored; a pulse in HOLD → PASS the next cycle, and a new AW passes through.
- Async reset asserted mid-ERR_B → all outputs 0 immediately, state PASS, table empty.
